// File: rtl/step_shaper_pkg.sv
// Shared types and default timing for the step_shaper output stage.
package step_shaper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam int CNT_W         = 16;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_DIR_SETUP = 50;
  localparam int DEF_PULSE_HI  = 30;
  localparam int DEF_PULSE_LO  = 30;

endpackage

// File: rtl/step_fifo.sv
// DEPTH x 1-bit first-word-fall-through FIFO holding queued step directions.
module step_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        din,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/step_shaper.sv
// Re-times queued step events into driver-compliant STEP/DIR pulses.
// Define STEP_SHAPER_DROPCNT_EN to build the saturating dropped-step counter.
module step_shaper
  import step_shaper_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DIR_SETUP = DEF_DIR_SETUP,
  parameter int PULSE_HI  = DEF_PULSE_HI,
  parameter int PULSE_LO  = DEF_PULSE_LO
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stepIn,
  input  logic        dirIn,
  input  logic        overflowClear,
  output logic        stepOut,
  output logic        dirOut,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] dropCount
);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     head, full, empty, pop, drop;
  logic [$clog2(DEPTH):0]   count;

  assign pop  = (state == IDLE) & ~empty;
  assign drop = stepIn & full & ~pop;
  assign busy = (state != IDLE) | (count != '0);

  step_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stepIn),
    .pop   (pop),
    .din   (dirIn),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // dirOut only moves on IDLE->SETUP, so it is stable through every pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      stepOut <= 1'b0;
      dirOut  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head != dirOut) begin
              dirOut <= head;
              cnt    <= CNT_W'(DIR_SETUP - 1);
              state  <= SETUP;
            end else begin
              stepOut <= 1'b1;
              cnt     <= CNT_W'(PULSE_HI - 1);
              state   <= HIGH;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            stepOut <= 1'b1;
            cnt     <= CNT_W'(PULSE_HI - 1);
            state   <= HIGH;
          end else cnt <= cnt - CNT_W'(1);
        end
        HIGH: begin
          if (cnt == '0) begin
            stepOut <= 1'b0;
            cnt     <= CNT_W'(PULSE_LO - 1);
            state   <= LOW;
          end else cnt <= cnt - CNT_W'(1);
        end
        LOW: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
    else if (overflowClear) overflow <= 1'b0;
  end

`ifdef STEP_SHAPER_DROPCNT_EN
  // A drop in the clear cycle is counted, leaving the counter at 1.
  always_ff @(posedge clk) begin
    if (rst)                                     dropCount <= 16'h0000;
    else if (overflowClear)                      dropCount <= drop ? 16'h0001 : 16'h0000;
    else if (drop && (dropCount != 16'hFFFF))    dropCount <= dropCount + 16'h0001;
  end
`else
  assign dropCount = 16'h0000;
`endif

endmodule

// File: tb/tb_step_shaper.sv
// Scoreboard bench for step_shaper: expected pulses queued by stimulus, checked by a monitor.
module tb_step_shaper;

  logic        clk, rst, stepIn, dirIn, overflowClear;
  logic        stepOut, dirOut, busy, overflow;
  logic [15:0] dropCount;

  typedef struct {
    logic   dir;
    longint t;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     total, passed;
  logic   prev_step, prev_dir;
  longint rise_t, last_dir_t, t0;
  longint exp_drop;

  step_shaper dut (
    .clk           (clk),
    .rst           (rst),
    .stepIn        (stepIn),
    .dirIn         (dirIn),
    .overflowClear (overflowClear),
    .stepOut       (stepOut),
    .dirOut        (dirOut),
    .busy          (busy),
    .overflow      (overflow),
    .dropCount     (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Monitor: every rising stepOut must match the head of the scoreboard.
  initial begin
    prev_step  = 1'b0;
    prev_dir   = 1'b0;
    rise_t     = 0;
    last_dir_t = -100000;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_step  = 1'b0;
      last_dir_t = -100000;
    end else begin
      if (dirOut !== prev_dir) last_dir_t = $time;
      if (stepOut && !prev_step) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_rise at %0t: stepOut rose with no pulse expected", $time);
        end else begin
          e = sb.pop_front();
          chk("rise_time", $time, e.t);
          chk("rise_dir", dirOut, e.dir);
          chk("dir_setup_ge_50", (($time - last_dir_t) >= 500) ? 1 : 0, 1);
        end
        rise_t = $time;
      end
      if (!stepOut && prev_step) chk("high_width", $time - rise_t, 300);
      prev_step = stepOut;
    end
    prev_dir = dirOut;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stepOut", stepOut, 0);
    chk("rst_dirOut", dirOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropCount", dropCount, 0);
    rst = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; stepIn = 1'b0; dirIn = 1'b0; overflowClear = 1'b0;
`ifdef STEP_SHAPER_DROPCNT_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif

    // Single step, same direction as reset dirOut.
    do_reset();
    t0 = $time;
    sb.push_back('{dir: 1'b0, t: t0 + 20});
    stepIn = 1'b1; dirIn = 1'b0;
    @(negedge clk); stepIn = 1'b0;
    repeat (60) @(negedge clk);
    chk("t1_busy_at_60", busy, 1);
    @(negedge clk);
    chk("t1_busy_at_61", busy, 0);
    chk("t1_dirOut", dirOut, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // Single step with reversal: DIR first, STEP 50 cycles later.
    do_reset();
    t0 = $time;
    sb.push_back('{dir: 1'b1, t: t0 + 520});
    stepIn = 1'b1; dirIn = 1'b1;
    @(negedge clk); stepIn = 1'b0; dirIn = 1'b0;
    @(negedge clk);
    chk("t2_dir_edge2", dirOut, 1);
    chk("t2_step_edge2", stepOut, 0);
    repeat (110) @(negedge clk);
    chk("t2_busy_done", busy, 0);
    chk("t2_dir_held", dirOut, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // Five back-to-back steps fit without overflow.
    do_reset();
    t0 = $time;
    for (int i = 0; i < 5; i++) sb.push_back('{dir: 1'b0, t: t0 + 20 + 610 * i});
    for (int i = 0; i < 5; i++) begin
      stepIn = 1'b1; dirIn = 1'b0;
      @(negedge clk);
    end
    stepIn = 1'b0;
    chk("t3_overflow", overflow, 0);
    repeat (302) @(negedge clk);
    chk("t3_busy_done", busy, 0);
    chk("t3_sb_empty", sb.size(), 0);

    // Ten back-to-back: five dropped, then clear, then a push into full on a pop cycle.
    do_reset();
    t0 = $time;
    for (int i = 0; i < 6; i++) sb.push_back('{dir: 1'b0, t: t0 + 20 + 610 * i});
    for (int i = 0; i < 10; i++) begin
      stepIn = 1'b1; dirIn = 1'b0;
      @(negedge clk);
    end
    chk("t4_overflow_set", overflow, 1);
    chk("t4_dropCount_5", dropCount, 5 * exp_drop);
    overflowClear = 1'b1;
    @(negedge clk);
    stepIn = 1'b0;
    chk("t4_set_wins", overflow, 1);
    chk("t4_dropCount_clr_drop", dropCount, exp_drop);
    @(negedge clk);
    overflowClear = 1'b0;
    chk("t4_overflow_clr", overflow, 0);
    chk("t4_dropCount_clr", dropCount, 0);
    repeat (50) @(negedge clk);
    stepIn = 1'b1;
    @(negedge clk);
    stepIn = 1'b0;
    repeat (310) @(negedge clk);
    chk("t4_full_pop_no_drop", overflow, 0);
    chk("t4_full_pop_dropCount", dropCount, 0);
    chk("t4_busy_done", busy, 0);
    chk("t4_sb_empty", sb.size(), 0);

    // Alternating directions: every step is a reversal.
    do_reset();
    t0 = $time;
    for (int i = 0; i < 4; i++) sb.push_back('{dir: ((i % 2) == 0), t: t0 + 520 + 1110 * i});
    for (int i = 0; i < 4; i++) begin
      stepIn = 1'b1; dirIn = ((i % 2) == 0);
      @(negedge clk);
    end
    stepIn = 1'b0; dirIn = 1'b0;
    repeat (442) @(negedge clk);
    chk("t5_busy_done", busy, 0);
    chk("t5_dirOut_last", dirOut, 0);
    chk("t5_sb_empty", sb.size(), 0);

    // Reset 10 cycles into HIGH with a second step still queued.
    do_reset();
    t0 = $time;
    sb.push_back('{dir: 1'b0, t: t0 + 20});
    stepIn = 1'b1; dirIn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stepIn = 1'b0;
    repeat (9) @(negedge clk);
    chk("t6_high_before_rst", stepOut, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_stepOut", stepOut, 0);
    chk("t6_rst_busy", busy, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_no_residual", stepOut, 0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
